// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: register/data widths, load funct3 encodings
// and the writeback starvation limit default.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a raw load word and sign- or
// zero-extends it according to the load funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] aligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   aligned = {{24{byte_v[7]}}, byte_v};
            F3_LH:   aligned = {{16{half_v[15]}}, half_v};
            F3_LBU:  aligned = {24'd0, byte_v};
            F3_LHU:  aligned = {16'd0, half_v};
            F3_LW:   aligned = word;
            // Undefined encodings pass the word through untouched.
            default: aligned = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates memory-stage and mul/div results onto the
// registered regfile write port and tracks pending mul/div destinations.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  mem_load,
    input  logic [2:0]            mem_funct3,
    input  logic [1:0]            mem_addr_lo,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [XLEN-1:0]       md_data,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic [REG_ADDR_W-1:0] wreg,
    output logic [XLEN-1:0]       wdata,
    output logic                  wen
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Handshake: a transfer happens in any cycle where valid and ready are both
    // high at the rising edge; a producer holds its payload stable until then.
    logic                  block;
    logic                  mem_xfer;
    logic                  md_xfer;
    logic [XLEN-1:0]       load_value;

    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic [31:0]           busy_q, busy_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;

    assign block     = (starve_cnt_q == LIMIT);
    assign mem_ready = ~block;
    assign md_ready  = ~(mem_valid & (|mem_rd)) | block;
    assign mem_xfer  = mem_valid & mem_ready;
    assign md_xfer   = md_valid & md_ready;

    load_align u_load_align (
        .word    (mem_data),
        .funct3  (mem_funct3),
        .addr_lo (mem_addr_lo),
        .aligned (load_value)
    );

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!md_valid || md_xfer) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // md_ready excludes a writing mem transfer, so at most one source writes.
    always_comb begin
        wen_d   = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (md_xfer && md_rd != '0) begin
            wen_d   = 1'b1;
            wreg_d  = md_rd;
            wdata_d = md_data;
        end else if (mem_xfer && mem_rd != '0) begin
            wen_d   = 1'b1;
            wreg_d  = mem_rd;
            wdata_d = mem_load ? load_value : mem_data;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (md_xfer && md_rd != '0) begin
            busy_d[md_rd] = 1'b0;
        end
        if (issue_en && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= 4'd0;
            busy_q       <= '0;
            wen_q        <= 1'b0;
            wreg_q       <= '0;
            wdata_q      <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            busy_q       <= busy_d;
            wen_q        <= wen_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy1 = busy_q[rs1];
    assign busy2 = busy_q[rs2];
    assign wen   = wen_q;
    assign wreg  = wreg_q;
    assign wdata = wdata_q;

endmodule
